// File: rtl/user_pulse_decoder.sv
// user_pulse_decoder
//   Receive side of the user-domain pulse generator. Synchronises pulse_i,
//   measures each pulse's period (rise to rise) and high time (rise to fall)
//   in clk_i cycles, then sorts every completed pulse into F1, F2 or error.
//   A capture ends on enable_i=0 or on the idle timeout (state DONE).
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   enable_i, clear_i    capture enable (level), counter/last clear (pulse)
//   pulse_i              asynchronous pulse line
//   f1_*/f2_*, tol_i     expected shapes and allowed +/- deviation
//   timeout_i            idle limit in cycles, 0 disables
//   f1/f2/err_cnt_o      saturating classification counters
//   last_period/high_o   most recent measurement; meas_valid_o strobes it
//   done_o, state_o      DONE flag and raw FSM state
module user_pulse_decoder #(
  parameter int CNT_WIDTH   = 16,
  parameter int PCNT_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  clear_i,
  input  logic                  pulse_i,
  input  logic [CNT_WIDTH-1:0]  f1_end_i,
  input  logic [CNT_WIDTH-1:0]  f1_switch_i,
  input  logic [CNT_WIDTH-1:0]  f2_end_i,
  input  logic [CNT_WIDTH-1:0]  f2_switch_i,
  input  logic [7:0]            tol_i,
  input  logic [CNT_WIDTH-1:0]  timeout_i,
  output logic [PCNT_WIDTH-1:0] f1_cnt_o,
  output logic [PCNT_WIDTH-1:0] f2_cnt_o,
  output logic [PCNT_WIDTH-1:0] err_cnt_o,
  output logic [CNT_WIDTH-1:0]  last_period_o,
  output logic [CNT_WIDTH-1:0]  last_high_o,
  output logic                  meas_valid_o,
  output logic                  done_o,
  output logic [2:0]            state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_WAIT_RISE = 3'd1, S_HIGH = 3'd2, S_LOW = 3'd3, S_DONE = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic                    hist_q, hist_d;
  logic [CNT_WIDTH-1:0]    timer_q, timer_d;
  logic [CNT_WIDTH-1:0]    high_q, high_d;
  logic [PCNT_WIDTH-1:0]   f1_cnt_q, f1_cnt_d, f2_cnt_q, f2_cnt_d, err_cnt_q, err_cnt_d;
  logic [CNT_WIDTH-1:0]    last_period_q, last_period_d, last_high_q, last_high_d;
  logic                    meas_valid_q, meas_valid_d;

  logic sync, rise, fall, active, timeout_hit, complete, f1_match, f2_match;

  function automatic logic [CNT_WIDTH-1:0] abs_diff(input logic [CNT_WIDTH-1:0] a,
                                                    input logic [CNT_WIDTH-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [PCNT_WIDTH-1:0] sat_inc(input logic [PCNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Edge detect after the synchroniser; rise and fall share the same latency
  // so the measured widths equal the widths on pulse_i.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pulse_i};
    sync   = sync_q[SYNC_STAGES-1];
    hist_d = sync;
    rise   = sync & ~hist_q;
    fall   = ~sync & hist_q;
  end

  always_comb begin
    active      = (state_q == S_WAIT_RISE) || (state_q == S_HIGH) || (state_q == S_LOW);
    timeout_hit = active && (timeout_i != '0) && (timer_q >= timeout_i) && !rise && !fall;
    state_d     = state_q;
    high_d      = high_q;
    complete    = 1'b0;
    case (state_q)
      S_IDLE:      if (enable_i) state_d = S_WAIT_RISE;
      S_WAIT_RISE: if (rise) state_d = S_HIGH;
                   else if (timeout_hit) state_d = S_DONE;
      S_HIGH:      if (fall) begin
                     high_d  = timer_q;
                     state_d = S_LOW;
                   end else if (timeout_hit) state_d = S_DONE;
      S_LOW:       if (rise) begin
                     complete = 1'b1;
                     state_d  = S_HIGH;
                   end else if (timeout_hit) state_d = S_DONE;
      S_DONE:      if (!enable_i) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    // Dropping enable aborts from any state; the pending pulse is not counted.
    if (!enable_i) begin
      state_d  = S_IDLE;
      complete = 1'b0;
    end

    // Timer value at a rise is the period, at a fall the high time.
    timer_d = timer_q;
    if (rise)                                        timer_d = CNT_WIDTH'(1);
    else if (state_q == S_IDLE && state_d == S_WAIT_RISE) timer_d = '0;
    else if (active && !(&timer_q))                  timer_d = timer_q + 1'b1;
  end

  // Classification of the measurement completing this cycle (timer_q = period).
  always_comb begin
    f1_match = (f1_end_i != '0) &&
               (abs_diff(timer_q, f1_end_i)    <= CNT_WIDTH'(tol_i)) &&
               (abs_diff(high_q,  f1_switch_i) <= CNT_WIDTH'(tol_i));
    f2_match = (f2_end_i != '0) &&
               (abs_diff(timer_q, f2_end_i)    <= CNT_WIDTH'(tol_i)) &&
               (abs_diff(high_q,  f2_switch_i) <= CNT_WIDTH'(tol_i));

    f1_cnt_d      = f1_cnt_q;
    f2_cnt_d      = f2_cnt_q;
    err_cnt_d     = err_cnt_q;
    last_period_d = last_period_q;
    last_high_d   = last_high_q;
    meas_valid_d  = complete;
    if (complete) begin
      last_period_d = timer_q;
      last_high_d   = high_q;
      if (f1_match)      f1_cnt_d  = sat_inc(f1_cnt_q);
      else if (f2_match) f2_cnt_d  = sat_inc(f2_cnt_q);
      else               err_cnt_d = sat_inc(err_cnt_q);
    end
    if (clear_i) begin
      f1_cnt_d      = '0;
      f2_cnt_d      = '0;
      err_cnt_d     = '0;
      last_period_d = '0;
      last_high_d   = '0;
      meas_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      sync_q        <= '0;
      hist_q        <= 1'b0;
      timer_q       <= '0;
      high_q        <= '0;
      f1_cnt_q      <= '0;
      f2_cnt_q      <= '0;
      err_cnt_q     <= '0;
      last_period_q <= '0;
      last_high_q   <= '0;
      meas_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      hist_q        <= hist_d;
      timer_q       <= timer_d;
      high_q        <= high_d;
      f1_cnt_q      <= f1_cnt_d;
      f2_cnt_q      <= f2_cnt_d;
      err_cnt_q     <= err_cnt_d;
      last_period_q <= last_period_d;
      last_high_q   <= last_high_d;
      meas_valid_q  <= meas_valid_d;
    end
  end

  assign f1_cnt_o      = f1_cnt_q;
  assign f2_cnt_o      = f2_cnt_q;
  assign err_cnt_o     = err_cnt_q;
  assign last_period_o = last_period_q;
  assign last_high_o   = last_high_q;
  assign meas_valid_o  = meas_valid_q;
  assign done_o        = (state_q == S_DONE);
  assign state_o       = state_q;

endmodule

// File: doc/user_pulse_decoder.md
Name: user_pulse_decoder

Overview:
- Receive-side counterpart of the user-domain pulse generator. Samples an incoming pulse line, measures each pulse's period and high time in clk_i cycles, and classifies each pulse against programmed F1/F2 shapes with a tolerance.
- Keeps per-class counts, an error count and the last measurement, plus an idle timeout that ends a capture.
- Sits in the user domain; the register file drives its config inputs and reads its status outputs.

Parameters:
- CNT_WIDTH, 16, width of the cycle timer, the shape inputs and the measurement outputs.
- PCNT_WIDTH, 8, width of the pulse/error counters.
- SYNC_STAGES, 2, synchronizer flops on pulse_i (≥2).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset. One clock; reset is synchronous and active-low.
- enable_i  in  1  capture enable (level)
- clear_i  in  1  zero counters and last_* (pulse)
- pulse_i  in  1  asynchronous pulse line
- f1_end_i  in  CNT_WIDTH  expected F1 period
- f1_switch_i  in  CNT_WIDTH  expected F1 high time
- f2_end_i  in  CNT_WIDTH  expected F2 period
- f2_switch_i  in  CNT_WIDTH  expected F2 high time
- tol_i  in  8  allowed ± deviation, in cycles
- timeout_i  in  CNT_WIDTH  idle limit in cycles; 0 = disabled
- f1_cnt_o  out  PCNT_WIDTH  pulses matched as F1
- f2_cnt_o  out  PCNT_WIDTH  pulses matched as F2
- err_cnt_o  out  PCNT_WIDTH  unmatched pulses
- last_period_o  out  CNT_WIDTH  last measured period
- last_high_o  out  CNT_WIDTH  last measured high time
- meas_valid_o  out  1  one-cycle strobe for a new measurement
- done_o  out  1  high while in DONE
- state_o  out  3  FSM state encoding: IDLE=0, WAIT_RISE=1, HIGH=2, LOW=3, DONE=4

Behaviour:
- Reset (rst_ni=0 at a clk_i edge): all outputs 0, state IDLE, synchronizer and timer cleared.
- Input path: pulse_i passes SYNC_STAGES flops, then one history flop. rise = sync & ~hist; fall = ~sync & hist. Both edges see equal latency, so widths are exact.
- Timer:
  - Set to 1 on a rise; otherwise increments in WAIT_RISE/HIGH/LOW; saturates at all-ones.
  - Set to 0 on IDLE→WAIT_RISE.
  - Measured period = timer at rise; measured high = timer at fall.
- FSM:
  - IDLE: enable_i=1 → WAIT_RISE.
  - WAIT_RISE: rise → HIGH. If the line is already high on entry, wait for a genuine rise.
  - HIGH: fall → latch high time, → LOW.
  - LOW: rise → measurement completes, → HIGH.
  - DONE: done_o=1; enable_i=0 → IDLE.
  - Timeout: in WAIT_RISE/HIGH/LOW, if timeout_i≠0, timer ≥ timeout_i and no edge this cycle → DONE. The pending pulse is discarded, not counted.
  - enable_i=0 in any state → IDLE next cycle. Counters and last_* are retained.
- Measurement completion (the rise in LOW), registered, visible the next cycle:
  - last_period_o and last_high_o updated; meas_valid_o=1 for 1 cycle.
  - F1 match: f1_end_i≠0 and |period−f1_end_i|≤tol_i and |high−f1_switch_i|≤tol_i. Absolute differences are computed unsigned without wrap.
  - F2 match: same rule with the F2 inputs, evaluated only if F1 does not match. F1 has priority.
  - Neither matches → err_cnt_o increments.
  - All counters saturate at 2^PCNT_WIDTH−1.
- The first rise of a capture only opens a period. N pulses produce N−1 measurements unless an (N+1)th rise arrives.
- clear_i: counters, last_* and meas_valid_o go to 0 next cycle. If it coincides with a completion, clear wins. FSM and timer are unaffected.
- Config inputs must be stable during capture. They are sampled combinationally at completion.

Test Plan:
- Reset/idle: pulse_i toggling with enable_i=0 → all outputs 0, state_o=0, no meas_valid_o.
- F1 train: f1_end=10, f1_switch=4, tol=0; 5 rises of period 10, high 4 → f1_cnt_o=4, err_cnt_o=0; last_period_o=10, last_high_o=4; 4 meas_valid_o strobes, each 10 cycles apart.
- Tolerance and priority: f1=(10,4), f2=(11,5), tol=1; pulses (11,5) → counted F1. With tol=0 → counted F2. Pulses (20,4) → err_cnt_o increments.
- Timeout: timeout_i=50; line stays low 60 cycles after a rise → DONE after timer reaches 50, done_o=1, no count change. enable_i=0 → IDLE.
- Saturation/clear: 300 matching F1 pulses → f1_cnt_o=255. clear_i on the same cycle as a completion → all counters 0 next cycle.
- Abort/reset mid-pulse: drop enable_i during HIGH → IDLE, counts kept. Assert rst_ni=0 mid-capture → all outputs 0 on the following edge.
